mux8_rr_scheduler: RTL and testbench
====================================

# mux8_rr_scheduler

Round-robin scheduler that shares the 8-to-1 multiplexer datapath among eight requesters. It arbitrates requests, drives the mux select and a one-hot grant, and bounds how long one lane may hold the mux while others wait. The selected lane's data is registered onto a single output with a valid flag. It sits directly in front of the 8-to-1 multiplexer block, or replaces the bare select inputs, wherever several sources contend for one output path.

## Interface
- W, default 1: data width per lane.
- MAX_HOLD, default 4: maximum consecutive grant cycles while another lane requests. Legal range is 1..15.

- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  global enable; low forces release and blocks new grants.
- req  in  8  per-lane request; bit i belongs to lane i.
- din  in  8*W  packed lane data; lane i is din[i*W +: W].
- gnt  out  8  one-hot grant; registered.
- sel  out  3  index of the granted lane; registered. Drives the mux select.
- busy  out  1  high while in the GRANT state.
- dout  out  W  registered data of the granted lane.
- dout_valid  out  1  qualifies dout.

## Operation
- **Reset (async):** all of the following clear immediately, independent of clk:
  - state=IDLE, ptr=0, hold_cnt=0
  - gnt=0, sel=0, busy=0, dout=0, dout_valid=0
- **Search:** combinational priority search over req, starting at ptr and rising with wrap 7→0. The first set bit wins.
- **IDLE:**
  - If en=1 and req≠0: load the search result into sel and gnt, set hold_cnt=1, go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- **GRANT, release conditions:** any one of the following triggers a release.
  - (a) req[sel]=0.
  - (b) hold_cnt==MAX_HOLD.
  - (c) en=0.
- **GRANT, no release:** hold_cnt increments and the grant holds.
- **Release on (a) or (b):**
  - Set ptr=sel+1 (mod 8).
  - Re-run the search with the new ptr on the same cycle's req.
  - If there is a winner, grant it at the next edge with hold_cnt=1. There is no idle bubble.
  - Otherwise go to IDLE with gnt=0.
- **Hold expiry with no other requester:** the search returns the same lane. The grant continues with hold_cnt restarting at 1.
- **Release on (c):** go to IDLE, gnt=0, ptr=sel+1. Condition (c) takes priority over (a) and (b).
- **Data path:**
  - Each edge, dout <= din[sel].
  - dout_valid <= (state==GRANT && req[sel] && en).
  - dout holds its last value when dout_valid=0.
- **sel in IDLE:** sel keeps its last value; gnt=0 is authoritative.
- **Hold counter:** 4-bit and saturating. It never exceeds MAX_HOLD.
- **Requester rules:** a requester keeps req high until it has consumed the data it needs. Dropping req mid-grant is legal and releases the grant at the next edge.

## Timing
- **Request to grant:** req sampled at edge k; gnt and sel are valid after edge k. Latency is 1 cycle.
- **Grant to data:** dout and dout_valid for grant cycle k+1 appear after edge k+1. Latency is 1 cycle from grant, 2 cycles from request.
- **Handoff:** a lane-to-lane change takes zero idle cycles; gnt changes one-hot to one-hot on a single edge.
- **Sustained throughput:** one W-bit word per cycle while any lane requests and en=1.
- **Fairness:** a lane continuously requesting waits at most 7*MAX_HOLD cycles.
- **Reset release:** the first grant is possible at the first edge after rst_n rises, provided en=1 and req≠0.

## Test plan
- **Reset mid-stream:** rst_n pulsed low asynchronously while lane 5 is granted → gnt=0, sel=0, busy=0, dout=0, dout_valid=0 before the next edge. After release, req=8'h01 → gnt=8'h01 after 1 edge.
- **Single requester:** req=8'h04, en=1, din lane 2=1 →
  - gnt=8'h04 and sel=2 after 1 edge.
  - dout=1 and dout_valid=1 one edge later.
  - The grant holds past MAX_HOLD with no gap.
- **All requesting:** req=8'hFF from reset, MAX_HOLD=4 → sel sequence 0,1,…,7,0, each lane granted exactly 4 cycles, busy continuously 1, no bubble.
- **Early drop:** lane 3 granted, req[3] drops at cycle 2 of the grant with req[5]=1 → gnt=8'h20 at the next edge. dout_valid=0 for the cycle req[3] was low.
- **Wrap-around:** ptr=7, req=8'h82 → lane 7 granted first, then lane 1 after expiry or drop. Lane 7 is not re-granted while req[1]=1 and the hold expired.
- **Enable gating:** en dropped while lane 4 is granted → gnt=0 and busy=0 at the next edge. With en reasserted and req=8'h11, lane 0 is granted next (ptr=5 wraps past 7).

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for an 8-to-1 mux: arbitrates req, drives one-hot gnt/sel, registers the selected lane's data.
// Latency: req -> gnt/sel 1 cycle; gnt -> dout/dout_valid 1 cycle (2 cycles from req).
// Backpressure: none on the output; a lane holds the mux at most MAX_HOLD cycles while others wait; en=0 forces release.
module mux8_rr_scheduler #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  output logic [7:0]     gnt,
  output logic [2:0]     sel,
  output logic           busy,
  output logic [W-1:0]   dout,
  output logic           dout_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0] state;
  logic [2:0] ptr;
  logic [3:0] hold_cnt;

  logic [2:0] sel_next_ptr;
  logic       idle_hit;
  logic [2:0] idle_idx;
  logic       rel_hit;
  logic [2:0] rel_idx;
  logic       rel_drop;
  logic       rel_expire;

  // Priority search: first set bit of r at or above p, wrapping 7 -> 0.
  // Returns {hit, index}.
  function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
    logic       hit;
    logic [2:0] idx;
    logic [2:0] cand;
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = p + 3'(i);
      if (!hit && r[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    return {hit, idx};
  endfunction

  assign sel_next_ptr = sel + 3'd1;
  assign rel_drop     = !req[sel];
  assign rel_expire   = (hold_cnt == HOLD_MAX);
  assign busy         = (state == GRANT);

  // Two searches in parallel: from ptr for a fresh grant, from sel+1 for a same-cycle handoff.
  always_comb begin
    {idle_hit, idle_idx} = rr_search(req, ptr);
    {rel_hit, rel_idx}   = rr_search(req, sel_next_ptr);
  end

  // Grant state machine: owns state, ptr, hold counter, sel and gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= 4'd0;
      sel      <= 3'd0;
      gnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && idle_hit) begin
            state    <= GRANT;
            sel      <= idle_idx;
            gnt      <= 8'd1 << idle_idx;
            hold_cnt <= 4'd1;
          end else begin
            gnt <= 8'd0;
          end
        end
        default: begin
          if (!en) begin
            // Enable drop wins over drop/expiry; pointer still advances past the owner.
            state    <= IDLE;
            gnt      <= 8'd0;
            hold_cnt <= 4'd0;
            ptr      <= sel_next_ptr;
          end else if (rel_drop || rel_expire) begin
            ptr <= sel_next_ptr;
            if (rel_hit) begin
              // Handoff with no bubble; may re-grant the same lane if it is alone.
              sel      <= rel_idx;
              gnt      <= 8'd1 << rel_idx;
              hold_cnt <= 4'd1;
            end else begin
              state    <= IDLE;
              gnt      <= 8'd0;
              hold_cnt <= 4'd0;
            end
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Output data register: captures the granted lane while it is actively requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (state == GRANT) && req[sel] && en;
      if ((state == GRANT) && req[sel] && en) begin
        dout <= din[int'(sel)*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: directed scenarios plus random traffic against a lane-level reference model.
// Latency: expectations are queued one cycle ahead of the edge they describe.
// Backpressure: none; the monitor pops one expectation per clock edge.
module tb_mux8_rr_scheduler;

  localparam int W  = 4;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [7:0]     req = 8'd0;
  logic [8*W-1:0] din = '0;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           busy;
  logic [W-1:0]   dout;
  logic           dout_valid;

  mux8_rr_scheduler #(.W(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .busy(busy), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   gnt;
    logic [2:0]   sel;
    logic         busy;
    logic [W-1:0] dout;
    logic         dv;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: which lane owns the mux, how long it has held it, where the next search starts.
  bit           m_busy;
  int           m_sel;
  int           m_ptr;
  int           m_hold;
  logic [W-1:0] m_dout;
  bit           m_dv;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_dout = '0; m_dv = 0;
  endtask

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  // Advance the model by one clock edge for the inputs now applied and queue what the DUT must show.
  task automatic step_and_push();
    exp_t e;
    int   w;
    m_dv = m_busy && req[m_sel] && en;
    if (m_dv) m_dout = din[m_sel*W +: W];
    if (!m_busy) begin
      w = first_from(req, m_ptr);
      if (en && w >= 0) begin
        m_busy = 1; m_sel = w; m_hold = 1;
      end
    end else if (!en) begin
      m_busy = 0; m_ptr = (m_sel + 1) % 8;
    end else if (!req[m_sel] || m_hold == MH) begin
      m_ptr = (m_sel + 1) % 8;
      w = first_from(req, m_ptr);
      if (w >= 0) begin
        m_sel = w; m_hold = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_hold = m_hold + 1;
    end
    e.gnt  = m_busy ? (8'd1 << m_sel) : 8'd0;
    e.sel  = 3'(m_sel);
    e.busy = m_busy;
    e.dout = m_dout;
    e.dv   = m_dv;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic en_v, input logic [7:0] req_v);
    @(negedge clk);
    en  = en_v;
    req = req_v;
    din = $urandom;
    step_and_push();
  endtask

  task automatic drive_n(input int n, input logic en_v, input logic [7:0] req_v);
    for (int i = 0; i < n; i++) drive(en_v, req_v);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", int'(gnt), int'(e.gnt));
        check("sel", int'(sel), int'(e.sel));
        check("busy", int'(busy), int'(e.busy));
        check("dout_valid", int'(dout_valid), int'(e.dv));
        check("dout", int'(dout), int'(e.dout));
      end
    end
  end

  initial begin
    logic [7:0] rq;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dv", int'(dout_valid), 0);
    rst_n = 1'b1;

    // All lanes requesting from reset: 0..7,0 rotation, MAX_HOLD cycles each.
    drive_n(34, 1'b1, 8'hFF);
    // Single requester keeps the mux past expiry.
    drive_n(12, 1'b1, 8'h04);
    // Early drop of lane 3 with lane 5 waiting.
    drive_n(1, 1'b0, 8'h00);
    drive_n(1, 1'b1, 8'h08);
    drive_n(1, 1'b1, 8'h28);
    drive_n(3, 1'b1, 8'h20);
    // Wrap-around: park ptr at 7, then lanes 7 and 1 contend.
    drive_n(1, 1'b0, 8'h00);
    drive_n(2, 1'b1, 8'h40);
    drive_n(1, 1'b1, 8'h00);
    drive_n(12, 1'b1, 8'h82);
    // Enable gating while lane 4 owns the mux, then lanes 0 and 4 contend.
    drive_n(1, 1'b0, 8'h00);
    drive_n(3, 1'b1, 8'h10);
    drive_n(1, 1'b0, 8'h10);
    drive_n(6, 1'b1, 8'h11);

    // Reset mid-stream while lane 5 is granted: outputs clear before the next edge.
    drive_n(1, 1'b0, 8'h00);
    drive_n(2, 1'b1, 8'h20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", int'(gnt), 0);
    check("async_sel", int'(sel), 0);
    check("async_busy", int'(busy), 0);
    check("async_dout", int'(dout), 0);
    check("async_dv", int'(dout_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_n(3, 1'b1, 8'h01);

    // Random traffic: sticky requests, occasional enable drops.
    rq = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      drive($urandom_range(0, 19) != 0, rq);
    end

    drive_n(2, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
